// File: rtl/fft_r2_stage.sv
// Radix-2 butterfly stage over a full N-point frame, valid/ready handshake, PIPE-deep pipeline, output frame counter.
// Optional macro FFT_R2_SCALE_EN: results halved with round-half-up (OW=W); otherwise full precision (OW=W+1).
`timescale 1ns/1ps
module fft_r2_stage #(
    parameter int N    = 16,
    parameter int W    = 17,
    parameter int SPAN = 8,
    parameter int PIPE = 1,
`ifdef FFT_R2_SCALE_EN
    localparam int OW  = W
`else
    localparam int OW  = W + 1
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_re,
    input  logic [N*W-1:0]  in_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*OW-1:0] out_re,
    output logic [N*OW-1:0] out_im,
    output logic [15:0]     frame_cnt
);

    logic [N*W-1:0]  bf_in_re, bf_in_im;
    logic            bf_valid, bf_ready;
    logic [N*OW-1:0] bf_re, bf_im;

    logic            out_valid_q;
    logic [N*OW-1:0] out_re_q, out_im_q;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    function automatic logic [W:0] sext(input logic [W-1:0] x);
        return {x[W-1], x};
    endfunction

    // s+1 cannot overflow W+1 bits, so dropping the LSB is the arithmetic shift.
    function automatic logic [OW-1:0] fmt(input logic [W:0] s);
`ifdef FFT_R2_SCALE_EN
        logic [W:0] u;
        u = s + (W+1)'(1);
        return u[W:1];
`else
        return s;
`endif
    endfunction

    // Index of the "a" element of pair p: groups of 2*SPAN, SPAN pairs per group.
    function automatic int pair_a(input int p);
        return (p / SPAN) * 2 * SPAN + (p % SPAN);
    endfunction

    always_comb begin
        bf_re = '0;
        bf_im = '0;
        for (int p = 0; p < N/2; p++) begin
            bf_re[pair_a(p)*OW +: OW] = fmt(sext(bf_in_re[pair_a(p)*W +: W])
                                          + sext(bf_in_re[(pair_a(p)+SPAN)*W +: W]));
            bf_re[(pair_a(p)+SPAN)*OW +: OW] = fmt(sext(bf_in_re[pair_a(p)*W +: W])
                                                 - sext(bf_in_re[(pair_a(p)+SPAN)*W +: W]));
            bf_im[pair_a(p)*OW +: OW] = fmt(sext(bf_in_im[pair_a(p)*W +: W])
                                          + sext(bf_in_im[(pair_a(p)+SPAN)*W +: W]));
            bf_im[(pair_a(p)+SPAN)*OW +: OW] = fmt(sext(bf_in_im[pair_a(p)*W +: W])
                                                 - sext(bf_in_im[(pair_a(p)+SPAN)*W +: W]));
        end
    end

    generate
        if (PIPE == 2) begin : g_pipe2
            logic           s1_valid_q;
            logic [N*W-1:0] s1_re_q, s1_im_q;

            assign in_ready = !s1_valid_q || bf_ready;
            assign bf_valid = s1_valid_q;
            assign bf_in_re = s1_re_q;
            assign bf_in_im = s1_im_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                    s1_re_q    <= '0;
                    s1_im_q    <= '0;
                end else if (in_ready) begin
                    s1_valid_q <= in_valid;
                    if (in_valid) begin
                        s1_re_q <= in_re;
                        s1_im_q <= in_im;
                    end
                end
            end
        end else begin : g_pipe1
            assign in_ready = bf_ready;
            assign bf_valid = in_valid;
            assign bf_in_re = in_re;
            assign bf_in_im = in_im;
            if (PIPE != 1) begin : g_bad_pipe
                $error("fft_r2_stage: PIPE must be 1 or 2");
            end
        end
    endgenerate

    assign bf_ready = !out_valid_q || out_ready;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_valid_q && out_ready) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // NOTE: data registers are reset only so traces start at zero; valids alone carry correctness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            if (bf_ready) begin
                out_valid_q <= bf_valid;
                if (bf_valid) begin
                    out_re_q <= bf_re;
                    out_im_q <= bf_im;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_r2_stage.sv
// Scoreboard bench for fft_r2_stage: one PIPE=1 and one PIPE=2 instance, random frames against a plain-integer model.
`timescale 1ns/1ps
module tb_fft_r2_stage;
    localparam int N    = 16;
    localparam int W    = 17;
    localparam int SPAN = 8;
`ifdef FFT_R2_SCALE_EN
    localparam int OW   = W;
`else
    localparam int OW   = W + 1;
`endif
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [N*OW-1:0] re;
        logic [N*OW-1:0] im;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid  [2];
    logic            in_ready  [2];
    logic            out_valid [2];
    logic            out_ready [2];
    logic [N*W-1:0]  in_re     [2];
    logic [N*W-1:0]  in_im     [2];
    logic [N*OW-1:0] out_re    [2];
    logic [N*OW-1:0] out_im    [2];
    logic [15:0]     frame_cnt [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit rnd_run     = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_r2_stage #(.N(N), .W(W), .SPAN(SPAN), .PIPE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_re(in_re[0]), .in_im(in_im[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_re(out_re[0]), .out_im(out_im[0]),
        .frame_cnt(frame_cnt[0])
    );

    fft_r2_stage #(.N(N), .W(W), .SPAN(SPAN), .PIPE(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_re(in_re[1]), .in_im(in_im[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_re(out_re[1]), .out_im(out_im[1]),
        .frame_cnt(frame_cnt[1])
    );

    task automatic check(input string name, input logic [N*OW-1:0] act, input logic [N*OW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model: integer arithmetic on whole frames ----------------
    function automatic int to_int(input logic signed [W-1:0] v);
        return int'(v);
    endfunction

    function automatic int out_int(input logic signed [OW-1:0] v);
        return int'(v);
    endfunction

    function automatic logic [OW-1:0] fmt_out(input int s);
        int          r;
        logic [31:0] t;
`ifdef FFT_R2_SCALE_EN
        // floor((s+1)/2)
        r = (s + 1 >= 0) ? (s + 1) / 2 : -((-(s + 1) + 1) / 2);
`else
        r = s;
`endif
        t = r;
        return t[OW-1:0];
    endfunction

    function automatic exp_t model(input logic [N*W-1:0] re, input logic [N*W-1:0] im);
        int   xr [N];
        int   xi [N];
        int   ia, ib;
        exp_t e;
        e = '0;
        for (int k = 0; k < N; k++) begin
            xr[k] = to_int(re[k*W +: W]);
            xi[k] = to_int(im[k*W +: W]);
        end
        for (int g = 0; g < N; g += 2*SPAN) begin
            for (int k = 0; k < SPAN; k++) begin
                ia = g + k;
                ib = ia + SPAN;
                e.re[ia*OW +: OW] = fmt_out(xr[ia] + xr[ib]);
                e.re[ib*OW +: OW] = fmt_out(xr[ia] - xr[ib]);
                e.im[ia*OW +: OW] = fmt_out(xi[ia] + xi[ib]);
                e.im[ib*OW +: OW] = fmt_out(xi[ia] - xi[ib]);
            end
        end
        return e;
    endfunction

    // ---------------- scoreboard monitors, sampled on the falling edge ----------------
    for (genvar gd = 0; gd < 2; gd++) begin : g_mon
        exp_t q[$];
        int   cnt = 0;
        always @(negedge clk) begin
            exp_t e;
            if (rst) begin
                q.delete();
                cnt = 0;
                check_int($sformatf("d%0d reset out_valid", gd), int'(out_valid[gd]), 0);
                check($sformatf("d%0d reset out_re", gd), out_re[gd], '0);
                check($sformatf("d%0d reset out_im", gd), out_im[gd], '0);
                check_int($sformatf("d%0d reset frame_cnt", gd), int'(frame_cnt[gd]), 0);
                check_int($sformatf("d%0d reset in_ready", gd), int'(in_ready[gd]), 1);
            end else begin
                check_int($sformatf("d%0d frame_cnt", gd), int'(frame_cnt[gd]), cnt);
                if (out_valid[gd] && out_ready[gd]) begin
                    if (q.size() == 0) begin
                        check_int($sformatf("d%0d unexpected out_valid", gd), int'(out_valid[gd]), 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("d%0d out_re", gd), out_re[gd], e.re);
                        check($sformatf("d%0d out_im", gd), out_im[gd], e.im);
                    end
                    cnt = (cnt + 1) % 65536;
                end
                if (in_valid[gd] && in_ready[gd]) q.push_back(model(in_re[gd], in_im[gd]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [N*W-1:0] rand_frame();
        logic [N*W-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 7))
                0:       f[k*W +: W] = MAXV;
                1:       f[k*W +: W] = MINV;
                default: f[k*W +: W] = W'($urandom);
            endcase
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        in_valid[d] = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input int d, input logic [N*W-1:0] re, input logic [N*W-1:0] im);
        int waited;
        waited = 0;
        in_valid[d] = 1'b1;
        in_re[d]    = re;
        in_im[d]    = im;
        forever begin
            @(negedge clk);
            if (in_ready[d]) break;
            waited++;
            if (waited > 200) begin
                check_int($sformatf("d%0d in_ready timeout", d), int'(in_ready[d]), 1);
                break;
            end
        end
        tick();
        in_valid[d] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b1;
            in_re[d]    = rand_frame();
            in_im[d]    = rand_frame();
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
    endtask

    // ---------------- directed tests ----------------
    task automatic ramp(input int d);
        logic [N*W-1:0] fr, fi;
        int er, er2, ei, ei2;
        for (int k = 0; k < N; k++) begin
            fr[k*W +: W] = W'(k);
            fi[k*W +: W] = W'(-k);
        end
        out_ready[d] = 1'b1;
        send(d, fr, fi);
        if (d == 1) tick();
        @(negedge clk);
        check_int($sformatf("d%0d ramp out_valid", d), int'(out_valid[d]), 1);
        for (int j = 0; j < SPAN; j++) begin
`ifdef FFT_R2_SCALE_EN
            er = j + 4;  er2 = -4; ei = -j - 4; ei2 = 4;
`else
            er = 2*j + 8; er2 = -8; ei = -(2*j + 8); ei2 = 8;
`endif
            check_int($sformatf("d%0d ramp re[%0d]", d, j), out_int(out_re[d][j*OW +: OW]), er);
            check_int($sformatf("d%0d ramp re[%0d]", d, j+8), out_int(out_re[d][(j+8)*OW +: OW]), er2);
            check_int($sformatf("d%0d ramp im[%0d]", d, j), out_int(out_im[d][j*OW +: OW]), ei);
            check_int($sformatf("d%0d ramp im[%0d]", d, j+8), out_int(out_im[d][(j+8)*OW +: OW]), ei2);
        end
        tick();
        idle(d, 3);
    endtask

    task automatic extremes(input int d);
        logic [N*W-1:0] f;
        int idx [8] = '{0, 8, 1, 9, 2, 10, 3, 11};
        int inv [8] = '{65535, 65535, -65536, 65535, 3, 0, -3, 0};
`ifdef FFT_R2_SCALE_EN
        int ev  [8] = '{65535, 0, 0, -65535, 2, 2, -1, -1};
`else
        int ev  [8] = '{131070, 0, -1, -131071, 3, 3, -3, -3};
`endif
        f = '0;
        for (int i = 0; i < 8; i++) f[idx[i]*W +: W] = W'(inv[i]);
        out_ready[d] = 1'b1;
        send(d, f, f);
        if (d == 1) tick();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_int($sformatf("d%0d extreme re[%0d]", d, idx[i]), out_int(out_re[d][idx[i]*OW +: OW]), ev[i]);
            check_int($sformatf("d%0d extreme im[%0d]", d, idx[i]), out_int(out_im[d][idx[i]*OW +: OW]), ev[i]);
        end
        tick();
        idle(d, 3);
    endtask

    task automatic rand_phase(input int d, input int n);
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 4) == 0) idle(d, 1);
                    send(d, rand_frame(), rand_frame());
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    tick();
                    out_ready[d] = ($urandom_range(0, 3) != 0);
                end
                out_ready[d] = 1'b1;
            end
        join
        idle(d, 6);
    endtask

    task automatic backpressure(input int d);
        pulse_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) send(d, rand_frame(), rand_frame());
            end
            begin
                tick();
                out_ready[d] = 1'b0;
                tick();
                tick();
                @(negedge clk);
                check_int($sformatf("d%0d in_ready while full", d), int'(in_ready[d]), 0);
                tick();
                out_ready[d] = 1'b1;
            end
        join
        idle(d, 6);
        @(negedge clk);
        check_int($sformatf("d%0d backpressure frame_cnt", d), int'(frame_cnt[d]), 4);
        tick();
    endtask

    task automatic stream(input int d);
        int t0;
        pulse_reset();
        t0 = cyc;
        for (int i = 0; i < 20; i++) send(d, rand_frame(), rand_frame());
        check_int($sformatf("d%0d cycles for 20 frames", d), cyc - t0, 20);
        repeat (d + 1) tick();
        @(negedge clk);
        check_int($sformatf("d%0d stream frame_cnt", d), int'(frame_cnt[d]), 20);
        tick();
        for (int i = 0; i < 10; i++) send(d, rand_frame(), rand_frame());
        in_valid[d] = 1'b1;
        in_re[d]    = rand_frame();
        in_im[d]    = rand_frame();
        rst         = 1'b1;
        @(negedge clk);
        check_int($sformatf("d%0d mid-stream reset out_valid", d), int'(out_valid[d]), 0);
        tick();
        rst         = 1'b0;
        in_valid[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_int($sformatf("d%0d out_valid after reset", d), int'(out_valid[d]), 0);
        end
        tick();
        for (int i = 0; i < 2; i++) send(d, rand_frame(), rand_frame());
        idle(d, 4);
        @(negedge clk);
        check_int($sformatf("d%0d frame_cnt restarted", d), int'(frame_cnt[d]), 2);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b1;
            in_re[d]     = rand_frame();
            in_im[d]     = rand_frame();
            out_ready[d] = $urandom_range(0, 1) != 0;
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        tick();

        for (int d = 0; d < 2; d++) begin
            ramp(d);
            extremes(d);
            rand_phase(d, 150);
            backpressure(d);
            stream(d);
        end

        check_int("d0 scoreboard empty", g_mon[0].q.size(), 0);
        check_int("d1 scoreboard empty", g_mon[1].q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
